axi4l_arbiter: RTL and testbench
================================

AXI4L_ARBITER -- requirements
Module: axi4l_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of upstream AXI4-Lite masters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 Parameter DATA_WIDTH, default 32, AXI data width (32 or 64); strobe width DATA_WIDTH/8.
REQ-004 aclk  in  1  sole clock, all logic rising-edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 m_aw{valid,addr,prot}/m_awready  in/out  NUM_MASTERS x {1,ADDR_WIDTH,3}/NUM_MASTERS  per-master write address channel.
REQ-007 m_w{valid,data,strb}/m_wready  in/out  NUM_MASTERS x {1,DATA_WIDTH,DATA_WIDTH/8}/NUM_MASTERS  per-master write data channel.
REQ-008 m_b{valid,resp}/m_bready  out/in  NUM_MASTERS x {1,2}/NUM_MASTERS  per-master write response; resp typed axi4l_resp_t.
REQ-009 m_ar{valid,addr,prot}/m_arready  in/out  NUM_MASTERS x {1,ADDR_WIDTH,3}/NUM_MASTERS  per-master read address channel.
REQ-010 m_r{valid,data,resp}/m_rready  out/in  NUM_MASTERS x {1,DATA_WIDTH,2}/NUM_MASTERS  per-master read data channel.
REQ-011 s_aw*, s_w*, s_b*, s_ar*, s_r*  mirrored  single-width  one downstream AXI4-Lite slave port, same fields.
REQ-012 grant  out  NUM_MASTERS  one-hot owner of slave port; zero when idle.

Function
REQ-013 SHALL serve exactly one transaction (read or write) at a time, end to end.
REQ-014 Request of master i SHALL be m_awvalid[i] | m_arvalid[i]; write SHALL win over read within one master.
REQ-015 Arbitration SHALL be round-robin: search starts at last-granted index + 1, wraps modulo NUM_MASTERS.
REQ-016 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP (plus ERR_WR, ERR_RD per REQ-027).
REQ-017 IDLE -> WR_REQ/RD_REQ on the cycle a request is seen; grant registered, slave valid asserted the following cycle (1-cycle arbitration latency).
REQ-018 WR_REQ: AW and W SHALL be forwarded independently; per-channel done flags; -> WR_RESP when both handshakes completed (same or different cycles).
REQ-019 WR_RESP: B forwarded to granted master; -> IDLE on m_bvalid&m_bready handshake.
REQ-020 RD_REQ -> RD_RESP on AR handshake; RD_RESP -> IDLE on R handshake.
REQ-021 Non-granted masters SHALL see all ready/valid outputs 0; slave valids SHALL be 0 in IDLE.
REQ-022 Slave-side valids SHALL stay asserted with stable payload until handshake (AXI rule).
REQ-023 Response returned to IDLE SHALL allow a new grant on the next cycle; no back-to-back overlap.
REQ-024 Master deasserting valid before handshake is a protocol violation; behaviour unspecified.

Reset
REQ-025 On aresetn low: state IDLE, grant 0, all valid/ready outputs 0, data outputs 0, last-grant pointer NUM_MASTERS-1 (master 0 first).
REQ-026 Reset mid-transaction SHALL abandon it immediately; no response issued.

Configuration
REQ-027 Macro AXI4L_ARB_ADDR_CHECK_EN: defined -> parameters SLV_BASE/SLV_MASK; address with (addr & SLV_MASK) != SLV_BASE SHALL not be forwarded; ERR_WR accepts AW and W then returns bresp RESP_DECERR; ERR_RD accepts AR then returns rdata 0, rresp RESP_DECERR; undefined -> all addresses forwarded, no ERR states.

Structure
REQ-028 axi4l_pkg SHALL hold axi4l_resp_t (existing) and new axi4l_arb_state_t enum.
REQ-029 Sub-module axi4l_rr_pick: combinational round-robin picker (request vector, pointer -> one-hot).

Verification
REQ-030 Single master 0 write addr 0x10 data 0xCAFE -> s_awvalid 1 cycle after request, m_bresp RESP_OKAY to master 0 only.
REQ-031 Masters 0,1 both read every cycle -> grant alternates 0,1,0,1; no master starved.
REQ-032 Slave AW ready 3 cycles before W ready -> single write forwarded, WR_RESP entered only after both.
REQ-033 Master 1 issues AW and AR together -> write served first, read next grant.
REQ-034 With AXI4L_ARB_ADDR_CHECK_EN, SLV_BASE 0x0, SLV_MASK 0xFFFF0000, read 0x20000 -> no s_arvalid, rresp RESP_DECERR.
REQ-035 aresetn low during RD_RESP -> all outputs 0 next edge, next request granted to master 0.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types: response codes and the arbiter state encoding.
package axi4l_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4l_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_ERR_WR,
    ST_ERR_RD
  } axi4l_arb_state_t;

endpackage

// File: rtl/axi4l_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping, as one-hot plus index.
module axi4l_rr_pick #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int cand;
    logic found;
    logic [IDX_W-1:0] cand_idx;
    gnt = '0;
    idx = '0;
    found = 1'b0;
    cand = 0;
    cand_idx = '0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr) + off) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axi4l_arbiter.sv
// N-to-1 AXI4-Lite arbiter serving one whole transaction at a time, round-robin between masters.
// Optional address decode error path enabled by defining AXI4L_ARB_ADDR_CHECK_EN.
module axi4l_arbiter
  import axi4l_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
`ifdef AXI4L_ARB_ADDR_CHECK_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] SLV_MASK = '0
`endif
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic [NUM_MASTERS-1:0]                       m_awvalid,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]       m_awaddr,
  input  logic [NUM_MASTERS-1:0][2:0]                  m_awprot,
  output logic [NUM_MASTERS-1:0]                       m_awready,
  input  logic [NUM_MASTERS-1:0]                       m_wvalid,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]       m_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]     m_wstrb,
  output logic [NUM_MASTERS-1:0]                       m_wready,
  output logic [NUM_MASTERS-1:0]                       m_bvalid,
  output axi4l_resp_t [NUM_MASTERS-1:0]                m_bresp,
  input  logic [NUM_MASTERS-1:0]                       m_bready,
  input  logic [NUM_MASTERS-1:0]                       m_arvalid,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]       m_araddr,
  input  logic [NUM_MASTERS-1:0][2:0]                  m_arprot,
  output logic [NUM_MASTERS-1:0]                       m_arready,
  output logic [NUM_MASTERS-1:0]                       m_rvalid,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]       m_rdata,
  output axi4l_resp_t [NUM_MASTERS-1:0]                m_rresp,
  input  logic [NUM_MASTERS-1:0]                       m_rready,
  output logic                                         s_awvalid,
  output logic [ADDR_WIDTH-1:0]                        s_awaddr,
  output logic [2:0]                                   s_awprot,
  input  logic                                         s_awready,
  output logic                                         s_wvalid,
  output logic [DATA_WIDTH-1:0]                        s_wdata,
  output logic [DATA_WIDTH/8-1:0]                      s_wstrb,
  input  logic                                         s_wready,
  input  logic                                         s_bvalid,
  input  axi4l_resp_t                                  s_bresp,
  output logic                                         s_bready,
  output logic                                         s_arvalid,
  output logic [ADDR_WIDTH-1:0]                        s_araddr,
  output logic [2:0]                                   s_arprot,
  input  logic                                         s_arready,
  input  logic                                         s_rvalid,
  input  logic [DATA_WIDTH-1:0]                        s_rdata,
  input  axi4l_resp_t                                  s_rresp,
  output logic                                         s_rready,
  output logic [NUM_MASTERS-1:0]                       grant
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  axi4l_arb_state_t state;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       gidx;
  logic                   aw_done;
  logic                   w_done;
  logic                   ar_done;

  assign req = m_awvalid | m_arvalid;

  axi4l_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req (req),
    .ptr (last_idx),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef AXI4L_ARB_ADDR_CHECK_EN
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
    return (addr & SLV_MASK) == SLV_BASE;
  endfunction
`endif

  // Slave-side request channels are registered: captured at grant, held until the slave handshakes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      grant     <= '0;
      gidx      <= '0;
      last_idx  <= IDX_W'(NUM_MASTERS - 1);
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
      s_awvalid <= 1'b0;
      s_awaddr  <= '0;
      s_awprot  <= '0;
      s_wvalid  <= 1'b0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      s_arvalid <= 1'b0;
      s_araddr  <= '0;
      s_arprot  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant    <= pick_gnt;
            gidx     <= pick_idx;
            last_idx <= pick_idx;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            ar_done  <= 1'b0;
            if (m_awvalid[pick_idx]) begin
`ifdef AXI4L_ARB_ADDR_CHECK_EN
              if (!addr_hit(m_awaddr[pick_idx])) state <= ST_ERR_WR;
              else
`endif
              begin
                state     <= ST_WR_REQ;
                s_awvalid <= 1'b1;
                s_awaddr  <= m_awaddr[pick_idx];
                s_awprot  <= m_awprot[pick_idx];
                s_wvalid  <= m_wvalid[pick_idx];
                s_wdata   <= m_wdata[pick_idx];
                s_wstrb   <= m_wstrb[pick_idx];
              end
            end else begin
`ifdef AXI4L_ARB_ADDR_CHECK_EN
              if (!addr_hit(m_araddr[pick_idx])) state <= ST_ERR_RD;
              else
`endif
              begin
                state     <= ST_RD_REQ;
                s_arvalid <= 1'b1;
                s_araddr  <= m_araddr[pick_idx];
                s_arprot  <= m_arprot[pick_idx];
              end
            end
          end
        end
        ST_WR_REQ: begin
          if (s_awvalid && s_awready) begin
            s_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          // W may arrive after AW; pick it up once the master presents it.
          if (s_wvalid && s_wready) begin
            s_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end else if (!s_wvalid && !w_done && m_wvalid[gidx]) begin
            s_wvalid <= 1'b1;
            s_wdata  <= m_wdata[gidx];
            s_wstrb  <= m_wstrb[gidx];
          end
          if ((aw_done || (s_awvalid && s_awready)) && (w_done || (s_wvalid && s_wready)))
            state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (s_bvalid && s_bready) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
        ST_RD_REQ: begin
          if (s_arvalid && s_arready) begin
            s_arvalid <= 1'b0;
            state     <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (s_rvalid && s_rready) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
`ifdef AXI4L_ARB_ADDR_CHECK_EN
        ST_ERR_WR: begin
          if (!aw_done && m_awvalid[gidx]) aw_done <= 1'b1;
          if (!w_done && m_wvalid[gidx]) w_done <= 1'b1;
          if (aw_done && w_done && m_bready[gidx]) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
        ST_ERR_RD: begin
          if (!ar_done && m_arvalid[gidx]) ar_done <= 1'b1;
          if (ar_done && m_rready[gidx]) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Master-side handshakes and responses are routed only to the granted master.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_arready = '0;
    m_bvalid  = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    s_bready  = 1'b0;
    s_rready  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_bresp[i] = RESP_OKAY;
      m_rresp[i] = RESP_OKAY;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        case (state)
          ST_WR_REQ: begin
            m_awready[i] = s_awvalid && s_awready;
            m_wready[i]  = s_wvalid && s_wready;
          end
          ST_WR_RESP: begin
            m_bvalid[i] = s_bvalid;
            m_bresp[i]  = s_bresp;
            s_bready    = m_bready[i];
          end
          ST_RD_REQ: m_arready[i] = s_arvalid && s_arready;
          ST_RD_RESP: begin
            m_rvalid[i] = s_rvalid;
            m_rdata[i]  = s_rdata;
            m_rresp[i]  = s_rresp;
            s_rready    = m_rready[i];
          end
`ifdef AXI4L_ARB_ADDR_CHECK_EN
          ST_ERR_WR: begin
            m_awready[i] = !aw_done && m_awvalid[i];
            m_wready[i]  = !w_done && m_wvalid[i];
            m_bvalid[i]  = aw_done && w_done;
            m_bresp[i]   = RESP_DECERR;
          end
          ST_ERR_RD: begin
            m_arready[i] = !ar_done && m_arvalid[i];
            m_rvalid[i]  = ar_done;
            m_rresp[i]   = RESP_DECERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi4l_arbiter.sv
// Directed, table-driven bench for axi4l_arbiter with two masters; cycle vectors plus reset and decode sequences.
module tb_axi4l_arbiter;
  import axi4l_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NV = 25;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [NM-1:0]           m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NM-1:0]           m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM-1:0][AW-1:0]   m_awaddr, m_araddr;
  logic [NM-1:0][2:0]      m_awprot, m_arprot;
  logic [NM-1:0][DW-1:0]   m_wdata, m_rdata;
  logic [NM-1:0][DW/8-1:0] m_wstrb;
  axi4l_resp_t [NM-1:0]    m_bresp, m_rresp;
  logic                    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic                    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0]           s_awaddr, s_araddr;
  logic [2:0]              s_awprot, s_arprot;
  logic [DW-1:0]           s_wdata, s_rdata;
  logic [DW/8-1:0]         s_wstrb;
  axi4l_resp_t             s_bresp, s_rresp;
  logic [NM-1:0]           grant;

  axi4l_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
`ifdef AXI4L_ARB_ADDR_CHECK_EN
    ,
    .SLV_BASE    (32'h0),
    .SLV_MASK    (32'hFFFF_0000)
`endif
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .grant(grant)
  );

  // Observation word: {grant, s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
  //                    m_awready, m_wready, m_arready, m_bvalid, m_rvalid}
  logic [16:0] obs;
  assign obs = {grant, s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
                m_awready, m_wready, m_arready, m_bvalid, m_rvalid};

  // sl = {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}
  typedef struct packed {
    logic [1:0]  aw;
    logic [1:0]  w;
    logic [1:0]  ar;
    logic [1:0]  bready;
    logic [1:0]  rready;
    logic [4:0]  sl;
    logic [16:0] want;
  } vec_t;

  vec_t vecs [NV];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    m_awvalid = v.aw;
    m_wvalid  = v.w;
    m_arvalid = v.ar;
    m_bready  = v.bready;
    m_rready  = v.rready;
    {s_awready, s_wready, s_arready, s_bvalid, s_rvalid} = v.sl;
    s_bresp = (idx == 21) ? RESP_SLVERR : RESP_OKAY;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, 17'b00_00000_00_00_00_00_00};
    vecs[1]  = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 5'b00000, 17'b00_00000_00_00_00_00_00};
    vecs[2]  = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 5'b10000, 17'b01_11000_01_00_00_00_00};
    vecs[3]  = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 5'b10000, 17'b01_01000_00_00_00_00_00};
    vecs[4]  = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 5'b10000, 17'b01_01000_00_00_00_00_00};
    vecs[5]  = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 5'b01000, 17'b01_01000_00_01_00_00_00};
    vecs[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00010, 17'b01_00000_00_00_00_01_00};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 5'b00010, 17'b01_00010_00_00_00_01_00};
    vecs[8]  = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 5'b00000, 17'b00_00000_00_00_00_00_00};
    vecs[9]  = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 5'b00100, 17'b10_00100_00_00_10_00_00};
    vecs[10] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 5'b00001, 17'b10_00001_00_00_00_00_10};
    vecs[11] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 5'b00000, 17'b00_00000_00_00_00_00_00};
    vecs[12] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 5'b00100, 17'b01_00100_00_00_01_00_00};
    vecs[13] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 5'b00001, 17'b01_00001_00_00_00_00_01};
    vecs[14] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 5'b00000, 17'b00_00000_00_00_00_00_00};
    vecs[15] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 5'b00000, 17'b10_00100_00_00_00_00_00};
    vecs[16] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 5'b00100, 17'b10_00100_00_00_10_00_00};
    vecs[17] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00001, 17'b10_00000_00_00_00_00_10};
    vecs[18] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 5'b00001, 17'b10_00001_00_00_00_00_10};
    vecs[19] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 5'b00000, 17'b00_00000_00_00_00_00_00};
    vecs[20] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 5'b11000, 17'b10_11000_10_10_00_00_00};
    vecs[21] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 5'b00010, 17'b10_00010_00_00_00_10_00};
    vecs[22] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 5'b00000, 17'b00_00000_00_00_00_00_00};
    vecs[23] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 5'b00100, 17'b10_00100_00_00_10_00_00};
    vecs[24] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00001, 17'b10_00000_00_00_00_00_10};

    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '0; m_rready = '0;
    m_awaddr[0] = 32'h10;   m_awaddr[1] = 32'h200;
    m_araddr[0] = 32'h40;   m_araddr[1] = 32'h84;
    m_wdata[0]  = 32'hCAFE; m_wdata[1]  = 32'hBEEF;
    m_wstrb[0]  = 4'hF;     m_wstrb[1]  = 4'h3;
    m_awprot = '0; m_arprot = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
    s_bresp = RESP_OKAY; s_rresp = RESP_OKAY; s_rdata = 32'h1234_5678;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_output("reset_outs", 64'(obs), 64'h0);
    check_output("reset_payload", {s_awaddr, s_wdata}, 64'h0);
    aresetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge aclk);
      #1;
      apply_stimulus(vecs[i], i);
      @(negedge aclk);
      check_output($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].want));
      if (i == 2) begin
        check_output("wr0_payload", {s_awaddr, s_wdata}, {32'h10, 32'hCAFE});
        check_output("wr0_strb", 64'(s_wstrb), 64'hF);
      end
      if (i == 9)  check_output("rd1_addr", 64'(s_araddr), 64'h84);
      if (i == 10) check_output("rd1_data", {m_rdata[1], m_rdata[0]}, {32'h1234_5678, 32'h0});
      if (i == 12) check_output("rd0_addr", 64'(s_araddr), 64'h40);
      if (i == 13) check_output("rd0_data", {m_rdata[1], m_rdata[0]}, {32'h0, 32'h1234_5678});
      if (i == 20) begin
        check_output("wr1_payload", {s_awaddr, s_wdata}, {32'h200, 32'hBEEF});
        check_output("wr1_strb", 64'(s_wstrb), 64'h3);
      end
      if (i == 21) check_output("wr1_bresp", 64'({m_bresp[1], m_bresp[0]}), 64'({RESP_SLVERR, RESP_OKAY}));
    end

    // Reset while master 1 sits in the read response phase with the slave offering data.
    @(posedge aclk);
    #1;
    m_rready = 2'b10;
    aresetn = 1'b0;
    @(negedge aclk);
    check_output("rst_mid_outs", 64'(obs), 64'h0);
    check_output("rst_mid_rdata", 64'(m_rdata[1]), 64'h0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_rready = 2'b00;
    s_rvalid = 1'b0;
    m_arvalid = 2'b11;
    @(posedge aclk);
    @(negedge aclk);
    check_output("rst_regrant", 64'({grant, s_arvalid}), 64'(3'b011));
    check_output("rst_regrant_addr", 64'(s_araddr), 64'h40);
    s_arready = 1'b1;
    @(posedge aclk);
    #1;
    m_arvalid = 2'b10;
    s_arready = 1'b0;
    s_rvalid = 1'b1;
    m_rready = 2'b01;
    @(negedge aclk);
    check_output("rst_regrant_r", 64'({m_rvalid, s_rready}), 64'(3'b011));
    @(posedge aclk);
    #1;
    s_rvalid = 1'b0;
    m_rready = 2'b00;
    m_arvalid = 2'b00;

`ifdef AXI4L_ARB_ADDR_CHECK_EN
    m_araddr[0] = 32'h0002_0000;
    m_arvalid = 2'b01;
    m_rready = 2'b01;
    @(posedge aclk);
    @(negedge aclk);
    check_output("dec_ar_accept", 64'({grant, s_arvalid, m_arready}), 64'(5'b01001));
    @(posedge aclk);
    #1;
    m_arvalid = 2'b00;
    @(negedge aclk);
    check_output("dec_rresp", 64'({s_arvalid, m_rvalid, m_rresp[0]}), 64'({1'b0, 2'b01, RESP_DECERR}));
    check_output("dec_rdata", 64'(m_rdata[0]), 64'h0);
    @(posedge aclk);
    #1;
    m_rready = 2'b00;
    @(negedge aclk);
    check_output("dec_idle", 64'(obs), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
